on_off_sequencer: RTL

- Avalon-MM controlled sequencer. Drives the scanner's on/off enable as a square wave.
- Half-period comes from the 26-bit on/off change value held by the existing change-period register block, wired in on `change_period`.
- Adds run/stop control, an optional external-trigger start, a finite cycle count, and status/done reporting.
- Sits between the change-period register block and the optical/LED enable fabric, on the same Avalon-MM bus.

---
 rtl/on_off_sequencer_if.sv | 24 ++
 rtl/on_off_sequencer.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/on_off_sequencer_if.sv
// rtl/on_off_sequencer_if.sv - Avalon-MM slave register bus for the on/off sequencer
interface on_off_sequencer_if;
    logic [1:0]  avs_s0_address;
    logic        avs_s0_read;
    logic        avs_s0_write;
    logic [31:0] avs_s0_readdata;
    logic [31:0] avs_s0_writedata;

    modport master (
        output avs_s0_address,
        output avs_s0_read,
        output avs_s0_write,
        output avs_s0_writedata,
        input  avs_s0_readdata
    );

    modport slave (
        input  avs_s0_address,
        input  avs_s0_read,
        input  avs_s0_write,
        input  avs_s0_writedata,
        output avs_s0_readdata
    );
endinterface

// File: rtl/on_off_sequencer.sv
// rtl/on_off_sequencer.sv - square-wave on/off enable sequencer with run/stop, trigger start and cycle limit
module on_off_sequencer #(
    parameter int CNT_W = 26,
    parameter int CYC_W = 16
) (
    input  logic                clk,
    input  logic                reset,
    on_off_sequencer_if.slave   avs,
    input  logic [CNT_W-1:0]    change_period,
    input  logic                trig_in,
    output logic                out_en,
    output logic                toggle_pulse,
    output logic                done_irq
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ARMED = 2'd1,
        S_ON    = 2'd2,
        S_OFF   = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic               run_q, run_d;
    logic               ext_q, ext_d;
    logic [CYC_W-1:0]   cycles_q, cycles_d;
    logic [CYC_W-1:0]   completed_q, completed_d;
    logic               done_q, done_d;
    logic [CNT_W-1:0]   period_q, period_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               trig_prev_q, trig_prev_d;
    logic               out_en_q, out_en_d;
    logic               toggle_q, toggle_d;

    logic ctrl_wr, cyc_wr, status_wr, stop, trig_edge, phase_end, start_on;

    always_comb begin
        ctrl_wr   = avs.avs_s0_write && (avs.avs_s0_address == 2'd0);
        cyc_wr    = avs.avs_s0_write && (avs.avs_s0_address == 2'd1);
        status_wr = avs.avs_s0_write && (avs.avs_s0_address == 2'd2);
        stop      = ctrl_wr && !avs.avs_s0_writedata[0];
        trig_edge = trig_in && !trig_prev_q;
        phase_end = (cnt_q == period_q - CNT_W'(1));
        start_on  = 1'b0;

        state_d     = state_q;
        run_d       = run_q;
        ext_d       = ext_q;
        cycles_d    = cycles_q;
        completed_d = completed_q;
        done_d      = done_q;
        period_d    = period_q;
        cnt_d       = cnt_q + CNT_W'(1);
        trig_prev_d = trig_in;

        if (cyc_wr)
            cycles_d = avs.avs_s0_writedata[CYC_W-1:0];
        if (status_wr && avs.avs_s0_writedata[2])
            done_d = 1'b0;
        if (ctrl_wr) begin
            ext_d = avs.avs_s0_writedata[1];
            if (state_q == S_IDLE) begin
                run_d = avs.avs_s0_writedata[0];
                if (avs.avs_s0_writedata[0]) begin
                    completed_d = '0;
                    done_d      = 1'b0;
                end
            end
        end

        if (stop) begin
            state_d = S_IDLE;
            run_d   = 1'b0;
            cnt_d   = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    cnt_d = '0;
                    if (run_d) begin
                        if (ext_d) state_d = S_ARMED;
                        else       start_on = 1'b1;
                    end
                end
                S_ARMED: begin
                    cnt_d = '0;
                    if (trig_edge) start_on = 1'b1;
                end
                S_ON: begin
                    if (phase_end) begin
                        state_d = S_OFF;
                        cnt_d   = '0;
                    end
                end
                S_OFF: begin
                    if (phase_end) begin
                        completed_d = completed_q + CYC_W'(1);
                        if ((cycles_q != '0) && (completed_d == cycles_q)) begin
                            state_d = S_IDLE;
                            done_d  = 1'b1;
                            run_d   = 1'b0;
                            cnt_d   = '0;
                        end else begin
                            start_on = 1'b1;
                        end
                    end
                end
                default: state_d = S_IDLE;
            endcase

            // A zero period aborts the run; run is dropped so IDLE does not immediately restart it.
            if (start_on) begin
                period_d = change_period;
                cnt_d    = '0;
                if (change_period == '0) begin
                    state_d = S_IDLE;
                    run_d   = 1'b0;
                end else begin
                    state_d = S_ON;
                end
            end
        end

        out_en_d = (state_d == S_ON);
        toggle_d = (out_en_d != out_en_q);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            run_q       <= 1'b0;
            ext_q       <= 1'b0;
            cycles_q    <= '0;
            completed_q <= '0;
            done_q      <= 1'b0;
            period_q    <= '0;
            cnt_q       <= '0;
            trig_prev_q <= 1'b0;
            out_en_q    <= 1'b0;
            toggle_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            run_q       <= run_d;
            ext_q       <= ext_d;
            cycles_q    <= cycles_d;
            completed_q <= completed_d;
            done_q      <= done_d;
            period_q    <= period_d;
            cnt_q       <= cnt_d;
            trig_prev_q <= trig_prev_d;
            out_en_q    <= out_en_d;
            toggle_q    <= toggle_d;
        end
    end

    always_comb begin
        avs.avs_s0_readdata = '0;
        if (avs.avs_s0_read) begin
            case (avs.avs_s0_address)
                2'd0: avs.avs_s0_readdata[1:0] = {ext_q, run_q};
                2'd1: avs.avs_s0_readdata[CYC_W-1:0] = cycles_q;
                2'd2: begin
                    avs.avs_s0_readdata[0]          = (state_q != S_IDLE);
                    avs.avs_s0_readdata[1]          = out_en_q;
                    avs.avs_s0_readdata[2]          = done_q;
                    avs.avs_s0_readdata[16 +: CYC_W] = completed_q;
                end
                default: avs.avs_s0_readdata = '0;
            endcase
        end
    end

    assign out_en       = out_en_q;
    assign toggle_pulse = toggle_q;
    assign done_irq     = done_q;

endmodule
